// File: rtl/struct_pckg.sv
// Shared types for the EX-stage redirect controller: FSM state and the
// trap > jump > branch source priority encoding.
`ifndef RNG_64
`define RNG_64 63:0
`endif

package struct_pckg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2
  } redirect_state_t;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JUMP   = 2'd2,
    SRC_TRAP   = 2'd3
  } redirect_src_t;

  // Callers must already have qualified jump/branch with EX valid and no stall.
  function automatic redirect_src_t sel_src(input logic trap, input logic jump,
                                            input logic branch);
    if (trap)        return SRC_TRAP;
    else if (jump)   return SRC_JUMP;
    else if (branch) return SRC_BRANCH;
    else             return SRC_NONE;
  endfunction

endpackage

// File: rtl/redirect_perf_cnt.sv
// Saturating event counter with synchronous active-high reset.
module redirect_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ex_redirect_ctrl.sv
// EX-stage redirect controller: captures taken jumps/branches and traps,
// offers the redirect PC to fetch and generates the pipeline flush pulses.
`ifndef RNG_64
`define RNG_64 63:0
`endif

module ex_redirect_ctrl
  import struct_pckg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ex_valid,
  input  logic               i_stall,
  input  logic               i_ex_jump_taken,
  input  logic               i_ex_branch_taken,
  input  logic [`RNG_64]     i_ex_jump_target,
  input  logic [`RNG_64]     i_ex_branch_target,
  input  logic               i_trap_req,
  input  logic [`RNG_64]     i_trap_target,
  input  logic               i_if_ready,
  output logic               o_redirect_valid,
  output logic [`RNG_64]     o_redirect_pc,
  output logic               o_flush_if,
  output logic               o_flush_id,
  output logic               o_flush_ex,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_redirect_cnt,
  output redirect_state_t    o_dbg_state
);

  redirect_state_t state_q, state_d;
  redirect_src_t   src;
  logic [`RNG_64]  pc_q, pc_d, sel_pc;
  logic            fl_if_q, fl_id_q, fl_ex_q;
  logic            fl_if_d, fl_id_d, fl_ex_d;
  logic            ex_ok;
  logic            accept;

  // Handshake: the redirect transfers on any cycle where o_redirect_valid and
  // i_if_ready are both high; valid and PC stay constant until that happens.
  // A trap arriving on the accepting cycle still counts the accept, then
  // re-enters PEND with the trap target (as if it hit the following DRAIN).
  always_comb begin
    ex_ok   = i_ex_valid & ~i_stall;
    src     = sel_src(i_trap_req, ex_ok & i_ex_jump_taken, ex_ok & i_ex_branch_taken);
    state_d = state_q;
    pc_d    = pc_q;
    fl_if_d = 1'b0;
    fl_id_d = 1'b0;
    fl_ex_d = 1'b0;
    accept  = 1'b0;

    case (src)
      SRC_TRAP:   sel_pc = i_trap_target;
      SRC_JUMP:   sel_pc = i_ex_jump_target;
      SRC_BRANCH: sel_pc = i_ex_branch_target;
      default:    sel_pc = '0;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (src != SRC_NONE) begin
          state_d = ST_PEND;
          pc_d    = sel_pc;
          fl_if_d = 1'b1;
          fl_id_d = 1'b1;
          fl_ex_d = (src == SRC_TRAP);
        end
      end
      ST_PEND: begin
        accept = i_if_ready;
        if (i_trap_req) begin
          pc_d    = i_trap_target;
          fl_if_d = 1'b1;
          fl_id_d = 1'b1;
          fl_ex_d = 1'b1;
        end else if (i_if_ready) begin
          state_d = ST_DRAIN;
          fl_if_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (i_trap_req) begin
          state_d = ST_PEND;
          pc_d    = i_trap_target;
          fl_if_d = 1'b1;
          fl_id_d = 1'b1;
          fl_ex_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      fl_if_q <= 1'b0;
      fl_id_q <= 1'b0;
      fl_ex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fl_if_q <= fl_if_d;
      fl_id_q <= fl_id_d;
      fl_ex_q <= fl_ex_d;
    end
  end

  redirect_perf_cnt #(.W(CNT_W)) u_perf_cnt (
    .clk (i_clk),
    .rst (i_rst),
    .inc (accept),
    .cnt (o_redirect_cnt)
  );

  assign o_redirect_valid = (state_q == ST_PEND);
  assign o_busy           = (state_q == ST_PEND);
  assign o_redirect_pc    = o_redirect_valid ? pc_q : '0;
  assign o_flush_if       = fl_if_q;
  assign o_flush_id       = fl_id_q;
  assign o_flush_ex       = fl_ex_q;
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_ex_redirect_ctrl.sv
// Bench for ex_redirect_ctrl: directed vector table, hand sequences for
// saturation and trap-on-accept, and random stimulus against a rule model.
module tb_ex_redirect_ctrl;
  import struct_pckg::*;

  typedef struct {
    bit          rst;
    bit          ev;
    bit          stall;
    bit          jt;
    bit          bt;
    logic [63:0] jtgt;
    logic [63:0] btgt;
    bit          trap;
    logic [63:0] ttgt;
    bit          rdy;
  } in_t;

  typedef struct {
    bit          valid;
    logic [63:0] pc;
    bit          fif;
    bit          fid;
    bit          fex;
    bit          busy;
    int unsigned cnt;
  } out_t;

  typedef struct {
    in_t  stim;
    out_t exp;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst, ex_valid, stall, jt, bt, trap, if_ready;
  logic [63:0] jtgt, btgt, ttgt;
  logic        r_valid, f_if, f_id, f_ex, busy;
  logic [63:0] r_pc;
  logic [31:0] cnt;
  redirect_state_t dbg_state;
  logic        r_valid4, f_if4, f_id4, f_ex4, busy4;
  logic [63:0] r_pc4;
  logic [3:0]  cnt4;
  redirect_state_t dbg_state4;

  always #5 clk = ~clk;

  ex_redirect_ctrl #(.CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .i_stall(stall),
    .i_ex_jump_taken(jt), .i_ex_branch_taken(bt),
    .i_ex_jump_target(jtgt), .i_ex_branch_target(btgt),
    .i_trap_req(trap), .i_trap_target(ttgt), .i_if_ready(if_ready),
    .o_redirect_valid(r_valid), .o_redirect_pc(r_pc),
    .o_flush_if(f_if), .o_flush_id(f_id), .o_flush_ex(f_ex),
    .o_busy(busy), .o_redirect_cnt(cnt), .o_dbg_state(dbg_state)
  );

  ex_redirect_ctrl #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .i_stall(stall),
    .i_ex_jump_taken(jt), .i_ex_branch_taken(bt),
    .i_ex_jump_target(jtgt), .i_ex_branch_target(btgt),
    .i_trap_req(trap), .i_trap_target(ttgt), .i_if_ready(if_ready),
    .o_redirect_valid(r_valid4), .o_redirect_pc(r_pc4),
    .o_flush_if(f_if4), .o_flush_id(f_id4), .o_flush_ex(f_ex4),
    .o_busy(busy4), .o_redirect_cnt(cnt4), .o_dbg_state(dbg_state4)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks whether a redirect is on offer, whether the one-cycle drain is in
  // progress, the offered PC, the flushes due next cycle and the accept total.
  bit          m_offer, m_drain, m_fif, m_fid, m_fex;
  logic [63:0] m_pc;
  longint unsigned m_cnt;

  task automatic model_update(input in_t v);
    bit accepted, ex_redir;
    if (v.rst) begin
      m_offer = 0; m_drain = 0; m_pc = '0; m_cnt = 0;
      m_fif = 0; m_fid = 0; m_fex = 0;
      return;
    end
    accepted = m_offer && v.rdy;
    ex_redir = v.ev && !v.stall && (v.jt || v.bt) && !m_offer && !m_drain;
    if (accepted && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    m_fif = 0; m_fid = 0; m_fex = 0;
    if (v.trap) begin
      m_offer = 1; m_drain = 0; m_pc = v.ttgt;
      m_fif = 1; m_fid = 1; m_fex = 1;
    end else if (ex_redir) begin
      m_offer = 1; m_pc = v.jt ? v.jtgt : v.btgt;
      m_fif = 1; m_fid = 1;
    end else if (accepted) begin
      m_offer = 0; m_drain = 1; m_fif = 1;
    end else if (m_drain) begin
      m_drain = 0;
    end
  endtask

  task automatic check_model(input string tag);
    redirect_state_t es;
    es = m_offer ? ST_PEND : (m_drain ? ST_DRAIN : ST_IDLE);
    check({tag, ".valid"}, r_valid, m_offer);
    check({tag, ".pc"},    r_pc,    m_offer ? m_pc : 64'h0);
    check({tag, ".fif"},   f_if,    m_fif);
    check({tag, ".fid"},   f_id,    m_fid);
    check({tag, ".fex"},   f_ex,    m_fex);
    check({tag, ".busy"},  busy,    m_offer);
    check({tag, ".cnt"},   cnt,     m_cnt);
    check({tag, ".cnt4"},  cnt4,    (m_cnt > 15) ? 64'd15 : m_cnt);
    check({tag, ".state"}, dbg_state, es);
  endtask

  // ---------------- driver ----------------
  task automatic step(input in_t v, input string tag);
    rst = v.rst; ex_valid = v.ev; stall = v.stall; jt = v.jt; bt = v.bt;
    jtgt = v.jtgt; btgt = v.btgt; trap = v.trap; ttgt = v.ttgt; if_ready = v.rdy;
    @(posedge clk);
    model_update(v);
    #1;
    check_model(tag);
  endtask

  function automatic in_t mk_in(bit r, bit e, bit s, bit j, bit b, logic [63:0] jg,
                                logic [63:0] bg, bit t, logic [63:0] tg, bit rd);
    in_t v;
    v.rst = r; v.ev = e; v.stall = s; v.jt = j; v.bt = b;
    v.jtgt = jg; v.btgt = bg; v.trap = t; v.ttgt = tg; v.rdy = rd;
    return v;
  endfunction

  function automatic out_t mk_out(bit va, logic [63:0] p, bit fi, bit fd, bit fe,
                                  bit bu, int unsigned c);
    out_t o;
    o.valid = va; o.pc = p; o.fif = fi; o.fid = fd; o.fex = fe; o.busy = bu; o.cnt = c;
    return o;
  endfunction

  vec_t tbl[$];

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.stim = i; v.exp = o;
    tbl.push_back(v);
  endtask

  in_t idle0, idle1, v;

  // ---------------- main test ----------------
  initial begin
    idle0 = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle1 = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // single branch, immediate accept
    add(mk_in(0,1,0,0,1,0,64'h1000,0,0,1),       mk_out(1,64'h1000,1,1,0,1,0));
    add(idle1,                                    mk_out(0,0,1,0,0,0,1));
    add(idle0,                                    mk_out(0,0,0,0,0,0,1));
    // jump beats branch, ready held low for three valid cycles
    add(mk_in(0,1,0,1,1,64'h2000,64'h3000,0,0,0), mk_out(1,64'h2000,1,1,0,1,1));
    add(idle0,                                    mk_out(1,64'h2000,0,0,0,1,1));
    add(idle0,                                    mk_out(1,64'h2000,0,0,0,1,1));
    add(idle0,                                    mk_out(1,64'h2000,0,0,0,1,1));
    add(idle1,                                    mk_out(0,0,1,0,0,0,2));
    add(idle0,                                    mk_out(0,0,0,0,0,0,2));
    // trap replaces a pending jump; later EX branch ignored
    add(mk_in(0,1,0,1,0,64'h2000,0,0,0,0),       mk_out(1,64'h2000,1,1,0,1,2));
    add(mk_in(0,0,0,0,0,0,0,1,64'h8000,0),       mk_out(1,64'h8000,1,1,1,1,2));
    add(mk_in(0,1,0,0,1,0,64'h3000,0,0,0),       mk_out(1,64'h8000,0,0,0,1,2));
    add(idle1,                                    mk_out(0,0,1,0,0,0,3));
    add(idle0,                                    mk_out(0,0,0,0,0,0,3));
    // stall blocks EX, not traps
    add(mk_in(0,1,1,0,1,0,64'h1000,0,0,0),       mk_out(0,0,0,0,0,0,3));
    add(mk_in(0,0,1,0,0,0,0,1,64'h9000,0),       mk_out(1,64'h9000,1,1,1,1,3));
    add(mk_in(0,0,1,0,0,0,0,0,0,1),              mk_out(0,0,1,0,0,0,4));
    // DRAIN ignores EX, takes traps
    add(mk_in(0,1,0,0,1,0,64'h5000,0,0,0),       mk_out(0,0,0,0,0,0,4));
    add(mk_in(0,1,0,0,1,0,64'h4000,0,0,1),       mk_out(1,64'h4000,1,1,0,1,4));
    add(idle1,                                    mk_out(0,0,1,0,0,0,5));
    add(mk_in(0,0,0,0,0,0,0,1,64'hA000,0),       mk_out(1,64'hA000,1,1,1,1,5));
    add(idle1,                                    mk_out(0,0,1,0,0,0,6));
    add(idle0,                                    mk_out(0,0,0,0,0,0,6));
    // reset in PEND beats simultaneous trap/jump/ready
    add(mk_in(0,1,0,0,1,0,64'h5000,0,0,0),       mk_out(1,64'h5000,1,1,0,1,6));
    add(mk_in(1,1,0,1,0,64'h7000,0,1,64'hB000,1), mk_out(0,0,0,0,0,0,0));
    add(mk_in(0,1,0,0,1,0,64'h1000,0,0,1),       mk_out(1,64'h1000,1,1,0,1,0));
    add(idle1,                                    mk_out(0,0,1,0,0,0,1));
    add(idle0,                                    mk_out(0,0,0,0,0,0,1));

    // reset state
    step(mk_in(1,0,0,0,0,0,0,0,0,0), "reset0");
    step(mk_in(1,0,0,0,0,0,0,0,0,0), "reset1");

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("row%0d", i);
      step(tbl[i].stim, t);
      check({t, ".tbl_valid"}, r_valid, tbl[i].exp.valid);
      check({t, ".tbl_pc"},    r_pc,    tbl[i].exp.pc);
      check({t, ".tbl_fif"},   f_if,    tbl[i].exp.fif);
      check({t, ".tbl_fid"},   f_id,    tbl[i].exp.fid);
      check({t, ".tbl_fex"},   f_ex,    tbl[i].exp.fex);
      check({t, ".tbl_busy"},  busy,    tbl[i].exp.busy);
      check({t, ".tbl_cnt"},   cnt,     64'(tbl[i].exp.cnt));
    end

    // trap on the same cycle fetch accepts: accept counted, trap re-offered
    step(mk_in(0,1,0,0,1,0,64'h6000,0,0,0), "tacc0");
    step(mk_in(0,0,0,0,0,0,0,1,64'hC000,1), "tacc1");
    check("tacc.pc",  r_pc, 64'hC000);
    check("tacc.cnt", cnt,  64'd2);
    step(idle1, "tacc2");
    step(idle0, "tacc3");

    // saturation of the 4-bit counter
    step(mk_in(1,0,0,0,0,0,0,0,0,0), "sat_rst");
    for (int k = 0; k < 14; k++) begin
      step(mk_in(0,1,0,0,1,0,64'h100 + 64'(k),0,0,0), "sat_cap");
      step(idle1, "sat_acc");
      step(idle0, "sat_idle");
    end
    check("sat.cnt4_pre", cnt4, 64'd14);
    for (int k = 0; k < 3; k++) begin
      step(mk_in(0,1,0,0,1,0,64'h200,0,0,0), "sat_cap");
      step(idle1, "sat_acc");
      step(idle0, "sat_idle");
      check($sformatf("sat.cnt4_%0d", k), cnt4, 64'hF);
    end
    check("sat.cnt32", cnt, 64'd17);

    // random stimulus against the model
    step(mk_in(1,0,0,0,0,0,0,0,0,0), "rnd_rst");
    for (int n = 0; n < 3000; n++) begin
      v.rst   = ($urandom_range(63) == 0);
      v.ev    = 1'($urandom_range(1));
      v.stall = ($urandom_range(3) == 0);
      v.jt    = ($urandom_range(2) == 0);
      v.bt    = ($urandom_range(2) == 0);
      v.jtgt  = {$urandom, $urandom};
      v.btgt  = {$urandom, $urandom};
      v.trap  = ($urandom_range(9) == 0);
      v.ttgt  = {$urandom, $urandom};
      v.rdy   = 1'($urandom_range(1));
      step(v, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
